jt10_adpcma_mix: RTL

Time-multiplexed mixer for the six YM2610 ADPCM-A channels. Consumes one already-attenuated 16-bit channel sample per `cen` slot, applies per-channel L/R panning and a debug mute mask, accumulates a full six-slot frame, and presents saturated 16-bit stereo totals. Its `snd_l`/`snd_r` outputs drive the ADPCM-A left/right inputs of the FM/ADPCM output accumulator, which samples them once per FM cycle.

---
 rtl/jt10_adpcma_mix_if.sv | 23 ++
 rtl/jt10_adpcma_mix.sv | 82 ++++++++
 2 files changed

// File: rtl/jt10_adpcma_mix_if.sv
// Slot-rate bus between the ADPCM-A channel engine and the stereo mixer:
// per-slot sample, pan and mute in; latched frame totals and slot index out.
interface jt10_adpcma_mix_if;
  logic               cen;
  logic               zero;
  logic signed [15:0] pcm_in;
  logic        [1:0]  lr;
  logic        [5:0]  ch_mute;
  logic signed [15:0] snd_l;
  logic signed [15:0] snd_r;
  logic               sample;
  logic        [2:0]  slot;

  modport master (
    output cen, zero, pcm_in, lr, ch_mute,
    input  snd_l, snd_r, sample, slot
  );

  modport slave (
    input  cen, zero, pcm_in, lr, ch_mute,
    output snd_l, snd_r, sample, slot
  );
endinterface

// File: rtl/jt10_adpcma_mix.sv
// Six-slot ADPCM-A stereo mixer: pans/mutes each slot sample, accumulates a
// frame and latches saturated 16-bit totals when the next frame starts.
module jt10_adpcma_mix #(
  parameter int ACCW = 19
) (
  input logic               rst,
  input logic               clk,
  jt10_adpcma_mix_if.slave  bus
);

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  function automatic logic signed [15:0] sat16(input logic signed [ACCW-1:0] v);
    if (v[ACCW-1:15] == {(ACCW-15){v[ACCW-1]}})
      return v[15:0];
    else
      return v[ACCW-1] ? 16'sh8000 : 16'sh7fff;
  endfunction

  function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [ACCW:0] v);
    if (v[ACCW] == v[ACCW-1])
      return v[ACCW-1:0];
    else
      return v[ACCW] ? ACC_MIN : ACC_MAX;
  endfunction

  logic signed [ACCW-1:0] acc_l_p0, acc_r_p0;
  logic signed [15:0]     snd_l_p1, snd_r_p1;
  logic                   vld_p1;
  logic        [2:0]      slot_p0;

  logic        [2:0]      idx;
  logic        [2:0]      slot_nxt;
  logic                   muted;
  logic signed [ACCW-1:0] l_in, r_in;
  logic signed [ACCW:0]   sum_l, sum_r;

  // Stage 0: slot decode, pan/mute gating and extended-width add
  always_comb begin
    idx      = bus.zero ? 3'd0 : slot_p0;
    slot_nxt = bus.zero ? 3'd1 : ((idx == 3'd5) ? 3'd0 : idx + 3'd1);
    muted    = bus.ch_mute[idx];
    l_in     = (bus.lr[1] && !muted) ? ACCW'(bus.pcm_in) : '0;
    r_in     = (bus.lr[0] && !muted) ? ACCW'(bus.pcm_in) : '0;
    sum_l    = {acc_l_p0[ACCW-1], acc_l_p0} + {l_in[ACCW-1], l_in};
    sum_r    = {acc_r_p0[ACCW-1], acc_r_p0} + {r_in[ACCW-1], r_in};
  end

  // Stage 1: accumulate, or close the frame and restart with this slot
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l_p0 <= '0;
      acc_r_p0 <= '0;
      snd_l_p1 <= '0;
      snd_r_p1 <= '0;
      vld_p1   <= 1'b0;
      slot_p0  <= 3'd0;
    end else begin
      vld_p1 <= 1'b0;
      if (bus.cen) begin
        slot_p0 <= slot_nxt;
        if (bus.zero) begin
          snd_l_p1 <= sat16(acc_l_p0);
          snd_r_p1 <= sat16(acc_r_p0);
          acc_l_p0 <= l_in;
          acc_r_p0 <= r_in;
          vld_p1   <= 1'b1;
        end else begin
          acc_l_p0 <= sat_acc(sum_l);
          acc_r_p0 <= sat_acc(sum_r);
        end
      end
    end
  end

  assign bus.snd_l  = snd_l_p1;
  assign bus.snd_r  = snd_r_p1;
  assign bus.sample = vld_p1;
  assign bus.slot   = slot_p0;

endmodule
